// File: rtl/ram2_arbiter_pkg.sv
// Shared definitions for the Ram2 arbiter: one-hot sequencer states, grant ports,
// inactive SRAM pin levels and the address zero-fill bit.
package ram2_arbiter_pkg;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_RD    = 6'b000010,
    ST_WR_SU = 6'b000100,
    ST_WR_PL = 6'b001000,
    ST_WR_HD = 6'b010000,
    ST_DONE  = 6'b100000
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

  // SRAM control pins are active-low
  localparam logic PIN_OFF = 1'b1;
  localparam logic PIN_ON  = 1'b0;

  localparam logic ADDR_FILL_BIT = 1'b0;
  localparam int   TIMER_W       = 8;

endpackage

// File: rtl/ram2_arbiter_mem_grant.sv
// Priority select between fetch and data requests, with a starvation counter that
// forces a fetch grant after STARVE_MAX consecutive data grants.
module mem_grant
  import ram2_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic  Clk,
  input  logic  Rst,
  input  logic  if_req_i,
  input  logic  dm_req_i,
  input  logic  grant_en_i,
  output port_e grant_port_o
);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  // Data wins by default; a waiting fetch wins once it has been passed over STARVE_MAX times
  always_comb begin
    starved      = if_req_i && (starve_q == CNT_W'(STARVE_MAX));
    grant_port_o = (dm_req_i && !starved) ? PORT_DM : PORT_IF;
    starve_d     = starve_q;
    if (!if_req_i) begin
      starve_d = '0;
    end else if (grant_en_i) begin
      if (grant_port_o == PORT_IF) starve_d = '0;
      else                         starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

endmodule

// File: rtl/ram2_arbiter.sv
// Shares the single Ram2 SRAM between instruction fetch and the data-memory stage,
// sequencing SRAM read/write timing and stalling the pipeline while an access is pending.
module ram2_arbiter
  import ram2_arbiter_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int RAM_AW     = 18,
  parameter int WR_SETUP   = 1,
  parameter int WR_PULSE   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall,
  output logic              Ram_EN,
  output logic              Ram_OE,
  output logic              Ram_WE,
  output logic [RAM_AW-1:0] Ram_address,
  inout  wire  [DATA_W-1:0] Ram_data
);

  localparam int FILL_W = RAM_AW - ADDR_W;

  state_e              state_q, state_d;
  port_e               port_q, port_d, grant_port;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic                if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
  logic                en_q, en_d, oe_q, oe_d, we_q, we_d, drive_q, drive_d;
  logic                grant_en;

  assign grant_en = (state_q == ST_IDLE) && (if_req || dm_req);

  mem_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .Clk          (Clk),
    .Rst          (Rst),
    .if_req_i     (if_req),
    .dm_req_i     (dm_req),
    .grant_en_i   (grant_en),
    .grant_port_o (grant_port)
  );

  // Sequencer: port, address and write data are latched at grant so later request changes are ignored
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          port_d  = grant_port;
          timer_d = '0;
          if (grant_port == PORT_DM) begin
            addr_d  = {{FILL_W{ADDR_FILL_BIT}}, dm_addr};
            wdata_d = dm_wdata;
            state_d = dm_we ? ST_WR_SU : ST_RD;
          end else begin
            addr_d  = {{FILL_W{ADDR_FILL_BIT}}, if_addr};
            state_d = ST_RD;
          end
        end
      end
      ST_RD:    state_d = ST_DONE;
      ST_WR_SU: begin
        if (timer_q == TIMER_W'(WR_SETUP - 1)) begin
          timer_d = '0;
          state_d = ST_WR_PL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WR_PL: begin
        if (timer_q == TIMER_W'(WR_PULSE - 1)) begin
          timer_d = '0;
          state_d = ST_WR_HD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WR_HD: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pin and handshake levels are decoded from the next state so every output is a flop
  always_comb begin
    en_d    = PIN_OFF;
    oe_d    = PIN_OFF;
    we_d    = PIN_OFF;
    drive_d = 1'b0;
    case (state_d)
      ST_RD: begin
        en_d = PIN_ON;
        oe_d = PIN_ON;
      end
      ST_WR_SU, ST_WR_HD: begin
        en_d    = PIN_ON;
        drive_d = 1'b1;
      end
      ST_WR_PL: begin
        en_d    = PIN_ON;
        we_d    = PIN_ON;
        drive_d = 1'b1;
      end
      default: ;
    endcase
    if_ready_d = (state_d == ST_DONE) && (port_d == PORT_IF);
    dm_ready_d = (state_d == ST_DONE) && (port_d == PORT_DM);
    if_rdata_d = ((state_q == ST_RD) && (port_q == PORT_IF)) ? Ram_data : if_rdata_q;
    dm_rdata_d = ((state_q == ST_RD) && (port_q == PORT_DM)) ? Ram_data : dm_rdata_q;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= ST_IDLE;
      port_q     <= PORT_IF;
      timer_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      en_q       <= PIN_OFF;
      oe_q       <= PIN_OFF;
      we_q       <= PIN_OFF;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
      en_q       <= en_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      drive_q    <= drive_d;
    end
  end

  assign Ram_data    = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign Ram_EN      = en_q;
  assign Ram_OE      = oe_q;
  assign Ram_WE      = we_q;
  assign Ram_address = addr_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_ready    = if_ready_q;
  assign dm_ready    = dm_ready_q;
  assign stall       = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_ram2_arbiter.sv
// Self-checking bench for ram2_arbiter: SRAM model on the pins, directed scenarios,
// then random request bursts checked against a grant-order/memory reference model.
module tb_ram2_arbiter;

  localparam int WR_SETUP   = 1;
  localparam int WR_PULSE   = 1;
  localparam int STARVE_MAX = 4;
  localparam int RD_LAT     = 2;
  localparam int WR_LAT     = WR_SETUP + WR_PULSE + 2;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [15:0] if_rdata, dm_rdata;
  logic        if_ready, dm_ready, stall;
  logic        Ram_EN, Ram_OE, Ram_WE;
  logic [17:0] Ram_address;
  wire  [15:0] Ram_data;

  logic [15:0] sram   [0:255];
  logic [15:0] refMem [0:255];
  bit          dmWeA   [0:7];
  logic [15:0] dmAddrA [0:7];
  logic [15:0] dmDataA [0:7];
  logic [15:0] expWdata = '0;
  logic [15:0] lastIf = '0;
  bit          ifSeen = 1'b0;
  int          nChecks = 0;
  int          nFails = 0;
  int          weLowCnt = 0;
  int          ifPos;

  ram2_arbiter #(
    .DATA_W(16), .ADDR_W(16), .RAM_AW(18),
    .WR_SETUP(WR_SETUP), .WR_PULSE(WR_PULSE), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall(stall),
    .Ram_EN(Ram_EN), .Ram_OE(Ram_OE), .Ram_WE(Ram_WE),
    .Ram_address(Ram_address), .Ram_data(Ram_data)
  );

  always #5 Clk = ~Clk;

  // Asynchronous SRAM: drives on EN&OE low, latches write data on the rising edge of WE
  assign Ram_data = (Ram_EN === 1'b0 && Ram_OE === 1'b0 && Ram_WE === 1'b1)
                    ? sram[Ram_address[7:0]] : 16'hzzzz;

  always @(posedge Ram_WE) begin
    if (Ram_EN === 1'b0 && Rst === 1'b1) sram[Ram_address[7:0]] <= Ram_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pin-level rules that must hold in every cycle
  always @(negedge Clk) begin
    if (Rst === 1'b1) begin
      if (Ram_WE === 1'b0) begin
        weLowCnt++;
        checkOutput("busWeWithOe", Ram_OE, 1);
      end
      if (Ram_EN === 1'b0 && Ram_OE === 1'b1) checkOutput("busWdata", Ram_data, expWdata);
      if (Ram_OE === 1'b0) checkOutput("busOeWithWe", Ram_WE, 1);
      checkOutput("readyExclusive", if_ready & dm_ready, 0);
    end
  end

  task automatic setDm(input int idx);
    dm_we    = dmWeA[idx];
    dm_addr  = dmAddrA[idx];
    dm_wdata = dmDataA[idx];
    if (dmWeA[idx]) expWdata = dmDataA[idx];
  endtask

  // Runs one fetch (optional) concurrently with nDm back-to-back data accesses
  task automatic applyStimulus(input bit ifOn, input logic [15:0] ifA, input int nDm);
    int          expPort[$];
    int          s, k, gap, expGap, lat, dmIdx;
    bit          ifPend;
    logic [15:0] a;
    s      = 0;
    k      = 0;
    ifPend = ifOn;
    while (ifPend || k < nDm) begin
      if (k < nDm && !(ifPend && s == STARVE_MAX)) begin
        expPort.push_back(1);
        s = ifPend ? ((s < STARVE_MAX) ? s + 1 : s) : 0;
        k++;
      end else begin
        expPort.push_back(0);
        s      = 0;
        ifPend = 1'b0;
      end
    end
    @(negedge Clk);
    if_req  = ifOn;
    if_addr = ifA;
    dmIdx   = 0;
    ifPos   = -1;
    if (nDm > 0) begin
      setDm(0);
      dm_req = 1'b1;
    end
    for (int e = 0; e < expPort.size(); e++) begin
      gap = 0;
      do begin
        @(negedge Clk);
        gap++;
        checkOutput("stall", stall, (if_req & ~if_ready) | (dm_req & ~dm_ready));
      end while (!(if_ready || dm_ready) && gap < 20);
      if (!(if_ready || dm_ready)) begin
        checkOutput("readyTimeout", 0, 1);
        if_req = 1'b0;
        dm_req = 1'b0;
        return;
      end
      lat    = (expPort[e] == 1 && dmIdx < nDm && dmWeA[dmIdx]) ? WR_LAT : RD_LAT;
      expGap = (e == 0) ? lat : lat + 1;
      checkOutput("grantPort", dm_ready, expPort[e]);
      checkOutput("latency", gap, expGap);
      if (dm_ready && dmIdx < nDm) begin
        a = dmAddrA[dmIdx];
        if (!dmWeA[dmIdx]) checkOutput("dmRdata", dm_rdata, refMem[a[7:0]]);
        else               refMem[a[7:0]] = dmDataA[dmIdx];
        dmIdx++;
        if (dmIdx < nDm) setDm(dmIdx);
        else             dm_req = 1'b0;
      end else if (if_ready) begin
        checkOutput("ifRdata", if_rdata, refMem[ifA[7:0]]);
        lastIf = refMem[ifA[7:0]];
        ifSeen = 1'b1;
        ifPos  = e;
        if_req = 1'b0;
      end
    end
    @(negedge Clk);
    if (ifSeen) checkOutput("ifRdataHold", if_rdata, lastIf);
  endtask

  initial begin
    int          gap, nDm;
    bit          ifOn;
    logic [15:0] ifA;
    for (int i = 0; i < 256; i++) begin
      sram[i]   = 16'($urandom);
      refMem[i] = sram[i];
    end
    sram[5]   = 16'h6A0F;
    refMem[5] = 16'h6A0F;

    // Reset state
    repeat (3) @(negedge Clk);
    checkOutput("rstEN", Ram_EN, 1);
    checkOutput("rstOE", Ram_OE, 1);
    checkOutput("rstWE", Ram_WE, 1);
    checkOutput("rstAddr", Ram_address, 0);
    checkOutput("rstIfReady", if_ready, 0);
    checkOutput("rstDmReady", dm_ready, 0);
    checkOutput("rstIfRdata", if_rdata, 0);
    checkOutput("rstDmRdata", dm_rdata, 0);
    checkOutput("rstStallIdle", stall, 0);
    if_req = 1'b1;
    #1 checkOutput("rstStallReq", stall, 1);
    if_req = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;

    // IF-only read
    @(negedge Clk);
    if_req  = 1'b1;
    if_addr = 16'h0005;
    @(negedge Clk);
    checkOutput("ifAddrPins", Ram_address, 18'h00005);
    checkOutput("ifOePin", Ram_OE, 0);
    checkOutput("ifNotYetReady", if_ready, 0);
    @(negedge Clk);
    checkOutput("ifReady", if_ready, 1);
    checkOutput("ifData", if_rdata, 16'h6A0F);
    if_req = 1'b0;
    @(negedge Clk);
    checkOutput("ifReadyPulse", if_ready, 0);
    lastIf = 16'h6A0F;
    ifSeen = 1'b1;

    // DM write, WE low for exactly one cycle
    weLowCnt   = 0;
    dmWeA[0]   = 1'b1;
    dmAddrA[0] = 16'h0040;
    dmDataA[0] = 16'hBEEF;
    applyStimulus(1'b0, 16'h0000, 1);
    checkOutput("weLowCycles", weLowCnt, 1);
    checkOutput("sramBeef", sram[8'h40], 16'hBEEF);

    // Simultaneous IF and DM read: DM first
    dmWeA[0]   = 1'b0;
    dmAddrA[0] = 16'h0040;
    applyStimulus(1'b1, 16'h0005, 1);
    checkOutput("simulIfSecond", ifPos, 1);
    checkOutput("simulDmData", dm_rdata, 16'hBEEF);

    // Starvation: IF forced after exactly STARVE_MAX data grants
    for (int i = 0; i < 5; i++) begin
      dmWeA[i]   = 1'b0;
      dmAddrA[i] = 16'(8'h10 + i);
    end
    applyStimulus(1'b1, 16'h0005, 5);
    checkOutput("starveIfPos", ifPos, STARVE_MAX);

    // Reset during the write pulse
    @(negedge Clk);
    expWdata = 16'h1234;
    dm_we    = 1'b1;
    dm_addr  = 16'h0041;
    dm_wdata = 16'h1234;
    dm_req   = 1'b1;
    gap      = 0;
    while (Ram_WE !== 1'b0 && gap < 10) begin
      @(negedge Clk);
      gap++;
    end
    checkOutput("midWrReachedPulse", Ram_WE, 0);
    #1 Rst = 1'b0;
    #1;
    checkOutput("midRstWE", Ram_WE, 1);
    checkOutput("midRstEN", Ram_EN, 1);
    checkOutput("midRstOE", Ram_OE, 1);
    checkOutput("midRstReady", dm_ready, 0);
    @(negedge Clk);
    Rst = 1'b1;
    gap = 0;
    do begin
      @(negedge Clk);
      gap++;
    end while (!dm_ready && gap < 20);
    checkOutput("midRstReissue", dm_ready, 1);
    checkOutput("midRstLatency", gap, WR_LAT);
    dm_req = 1'b0;
    refMem[8'h41] = 16'h1234;
    @(negedge Clk);
    checkOutput("midRstSram", sram[8'h41], 16'h1234);
    ifSeen = 1'b0;

    // Random bursts
    for (int it = 0; it < 30; it++) begin
      ifOn = 1'($urandom_range(0, 1));
      nDm  = int'($urandom_range(0, 6));
      if (!ifOn && nDm == 0) nDm = 1;
      ifA = 16'($urandom_range(0, 255));
      for (int i = 0; i < nDm; i++) begin
        dmWeA[i]   = 1'($urandom_range(0, 1));
        dmAddrA[i] = 16'($urandom_range(0, 255));
        dmDataA[i] = 16'($urandom);
      end
      applyStimulus(ifOn, ifA, nDm);
    end

    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
